// File: rtl/bram_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bram_rd_arbiter
// Description : Round-robin arbiter and burst sequencer for one shared BRAM
//               read port. Grants one (base, len) burst at a time, drives
//               enb/addrb, and returns read data tagged with a one-hot
//               requester valid after a fixed read latency.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_rd_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_W     = 32,
  parameter int LEN_W      = 16,
  parameter int RD_LATENCY = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_base_i,
  input  logic [NUM_REQ*LEN_W-1:0]    req_len_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  input  logic [DATA_WIDTH-1:0]       bram_dout,
  output logic                        bram_enb,
  output logic [ADDR_W-1:0]           bram_addrb,
  output logic [DATA_WIDTH-1:0]       rd_data_o,
  output logic [NUM_REQ-1:0]          rd_valid_o,
  output logic                        rd_last_o,
  output logic [NUM_REQ-1:0]          done_o,
  output logic                        busy_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BURST = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] ZDONE = 2'd3;

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [IDX_W-1:0]      rr_ptr;
  logic [IDX_W-1:0]      gnt_idx;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_found;
  int                    cand;
  logic [ADDR_W-1:0]     base_q;
  logic [LEN_W-1:0]      len_q;
  logic [LEN_W-1:0]      cnt;
  logic [ADDR_W-1:0]     sel_base;
  logic [LEN_W-1:0]      sel_len;
  logic [NUM_REQ-1:0]    gnt_onehot;
  logic                  accept;
  logic                  burst_end;
  logic                  complete;
  logic [RD_LATENCY-1:0] vld_sr;
  logic [RD_LATENCY-1:0] last_sr;
  logic                  ret_valid;
  logic                  ret_last;

  // Circular search for the first valid requester at or after rr_ptr.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(rr_ptr) + i;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!pick_found && req_valid_i[cand]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end

  // Grants only happen from IDLE and never while reset is held.
  assign accept      = rst_n && (state == IDLE) && pick_found;
  assign sel_base    = req_base_i[pick_idx*ADDR_W +: ADDR_W];
  assign sel_len     = req_len_i[pick_idx*LEN_W +: LEN_W];
  assign req_ready_o = accept ? (NUM_REQ'(1) << pick_idx) : '0;

  assign burst_end  = (state == BURST) && (cnt == len_q - LEN_W'(1));
  assign complete   = ret_last || (state == ZDONE);
  assign gnt_onehot = NUM_REQ'(1) << gnt_idx;

  // Next-state logic; DRAIN ends when the last word comes back out of the pipe.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (sel_len == '0) ? ZDONE : BURST;
      BURST:   if (burst_end) state_nxt = DRAIN;
      DRAIN:   if (ret_last) state_nxt = IDLE;
      ZDONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Latch the granted burst and step the word counter through it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base_q  <= '0;
      len_q   <= '0;
      gnt_idx <= '0;
      cnt     <= '0;
    end else if (accept) begin
      base_q  <= sel_base;
      len_q   <= sel_len;
      gnt_idx <= pick_idx;
      cnt     <= '0;
    end else if (state == BURST) begin
      cnt <= burst_end ? '0 : cnt + LEN_W'(1);
    end
  end

  // Round-robin pointer moves past the requester whose burst just completed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (complete) begin
      rr_ptr <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
    end
  end

  // Return-path pipe carrying {valid, last} alongside the BRAM read latency.
  generate
    if (RD_LATENCY == 1) begin : g_ret_single
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          vld_sr  <= '0;
          last_sr <= '0;
        end else begin
          vld_sr  <= bram_enb;
          last_sr <= burst_end;
        end
      end
    end else begin : g_ret_multi
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          vld_sr  <= '0;
          last_sr <= '0;
        end else begin
          vld_sr  <= {vld_sr[RD_LATENCY-2:0], bram_enb};
          last_sr <= {last_sr[RD_LATENCY-2:0], burst_end};
        end
      end
    end
  endgenerate

  assign ret_valid = vld_sr[RD_LATENCY-1];
  assign ret_last  = last_sr[RD_LATENCY-1];

  // Address offset is resized to the address width; the sum wraps silently.
  assign bram_enb   = (state == BURST);
  assign bram_addrb = bram_enb ? (base_q + ADDR_W'(cnt)) : '0;
  assign rd_data_o  = bram_dout;
  assign rd_valid_o = ret_valid ? gnt_onehot : '0;
  assign rd_last_o  = ret_last;
  assign done_o     = complete ? gnt_onehot : '0;
  assign busy_o     = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_bram_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bram_rd_arbiter
// Description : Self-checking bench for bram_rd_arbiter: directed vector
//               table, multi-cycle corner sequences, and a randomized run
//               against a transaction-level timeline model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_rd_arbiter;

  localparam int N        = 3;
  localparam int DW       = 8;
  localparam int AW       = 8;
  localparam int LW       = 16;
  localparam int LAT      = 2;
  localparam int RAND_CYC = 1500;
  localparam int HIST     = 4096;
  localparam int NVEC     = 5;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [N-1:0]        req_valid = '0;
  logic [N*AW-1:0]     req_base = '0;
  logic [N*LW-1:0]     req_len = '0;
  logic [N-1:0]        req_ready;
  logic [DW-1:0]       bram_dout;
  logic                bram_enb;
  logic [AW-1:0]       bram_addrb;
  logic [DW-1:0]       rd_data;
  logic [N-1:0]        rd_valid;
  logic                rd_last;
  logic [N-1:0]        done;
  logic                busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  bram_rd_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_W(AW), .LEN_W(LW), .RD_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_base_i(req_base), .req_len_i(req_len),
    .req_ready_o(req_ready), .bram_dout(bram_dout), .bram_enb(bram_enb),
    .bram_addrb(bram_addrb), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
    .rd_last_o(rd_last), .done_o(done), .busy_o(busy)
  );

  // BRAM stand-in: mem[a] = a with a two-cycle read pipeline.
  logic [AW-1:0] bram_p1;
  always @(posedge clk) begin
    bram_p1   <= bram_addrb;
    bram_dout <= bram_p1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive_req(input int r, input logic v, input logic [AW-1:0] b, input logic [LW-1:0] l);
    req_valid[r]         = v;
    req_base[r*AW +: AW] = b;
    req_len[r*LW +: LW]  = l;
  endtask

  task automatic do_reset();
    req_valid = '0;
    rst_n = 1'b0;
    repeat (3) next_cycle();
    rst_n = 1'b1;
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  typedef struct {
    int            rid;
    logic [AW-1:0] base;
    int            len;
    logic [AW-1:0] a_first;
    logic [AW-1:0] a_last;
    int            done_k;
    int            idle_k;
  } vec_t;

  vec_t vecs [NVEC];

  // Timeline model storage for the randomized run.
  logic [N-1:0]  e_ready [HIST];
  logic          e_en    [HIST];
  logic [AW-1:0] e_addr  [HIST];
  logic [N-1:0]  e_vld   [HIST];
  logic [DW-1:0] e_data  [HIST];
  logic          e_last  [HIST];
  logic [N-1:0]  e_done  [HIST];
  logic          e_busy  [HIST];

  logic          pend [N];
  logic [AW-1:0] rb   [N];
  logic [LW-1:0] rl   [N];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int            gid  [4];
    int            gcyc [4];
    int            exp_order [4];
    int            ng;
    logic          overlap;
    logic          seen;
    logic          in_burst;
    logic          in_ret;
    logic [AW-1:0] ed;
    int            ptr;
    int            free_at;
    int            granted_last;
    int            g;
    int            cl;

    vecs[0] = '{0, 8'h10, 4, 8'h10, 8'h13, 6, 7};
    vecs[1] = '{1, 8'h00, 0, 8'h00, 8'h00, 1, 2};
    vecs[2] = '{2, 8'hFE, 3, 8'hFE, 8'h00, 5, 6};
    vecs[3] = '{1, 8'h80, 1, 8'h80, 8'h80, 3, 4};
    vecs[4] = '{0, 8'hFF, 2, 8'hFF, 8'h00, 4, 5};
    exp_order = '{0, 1, 2, 0};

    // ---------------- reset state ----------------
    repeat (3) next_cycle();
    sample();
    chk("rst_ready", req_ready, 0);
    chk("rst_enb", bram_enb, 0);
    chk("rst_addrb", bram_addrb, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_last", rd_last, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    next_cycle();
    rst_n = 1'b1;

    // ---------------- directed vector table ----------------
    for (int v = 0; v < NVEC; v++) begin
      drive_req(vecs[v].rid, 1'b1, vecs[v].base, LW'(vecs[v].len));
      sample();
      chk("tbl_ready", req_ready, N'(1) << vecs[v].rid);
      next_cycle();
      drive_req(vecs[v].rid, 1'b0, '0, '0);
      for (int k = 1; k <= vecs[v].idle_k; k++) begin
        if (k > 1) next_cycle();
        sample();
        in_burst = (vecs[v].len > 0) && (k <= vecs[v].len);
        in_ret   = (vecs[v].len > 0) && (k >= 1 + LAT) && (k <= vecs[v].len + LAT);
        chk("tbl_enb", bram_enb, in_burst);
        if (in_burst && k == 1) chk("tbl_addr_first", bram_addrb, vecs[v].a_first);
        if (in_burst && k == vecs[v].len) chk("tbl_addr_last", bram_addrb, vecs[v].a_last);
        chk("tbl_rd_valid", rd_valid, in_ret ? (N'(1) << vecs[v].rid) : N'(0));
        if (in_ret) begin
          ed = vecs[v].a_first + AW'(k - 1 - LAT);
          chk("tbl_rd_data", rd_data, ed);
        end
        chk("tbl_done", done, (k == vecs[v].done_k) ? (N'(1) << vecs[v].rid) : N'(0));
        chk("tbl_rd_last", rd_last, (vecs[v].len > 0) && (k == vecs[v].done_k));
        chk("tbl_busy", busy, k < vecs[v].idle_k);
      end
      next_cycle();
    end

    // ---------------- round-robin with all requesters held ----------------
    do_reset();
    for (int r = 0; r < N; r++) drive_req(r, 1'b1, AW'(32 * (r + 1)), LW'(2));
    ng = 0;
    overlap = 1'b0;
    for (int i = 0; i < 4; i++) begin gid[i] = -1; gcyc[i] = -100; end
    for (int c = 0; c < 40 && ng < 4; c++) begin
      sample();
      if ($countones(rd_valid) > 1) overlap = 1'b1;
      if (req_ready != '0) begin
        gid[ng]  = onehot_idx(req_ready);
        gcyc[ng] = c;
        ng++;
      end
      next_cycle();
    end
    req_valid = '0;
    for (int c = 0; c < 10; c++) begin
      sample();
      if ($countones(rd_valid) > 1) overlap = 1'b1;
      next_cycle();
    end
    for (int i = 0; i < 4; i++) chk("rr_grant_order", gid[i], exp_order[i]);
    for (int i = 1; i < 4; i++) chk("rr_grant_spacing", gcyc[i] - gcyc[i-1], 5);
    chk("rr_no_overlap", overlap, 0);

    // ---------------- fairness after serving req1 ----------------
    do_reset();
    drive_req(1, 1'b1, 8'h50, LW'(1));
    sample();
    chk("fair_req1", req_ready, 3'b010);
    next_cycle();
    drive_req(1, 1'b0, '0, '0);
    for (int c = 0; c < 10; c++) begin
      sample();
      if (!busy) break;
      next_cycle();
    end
    chk("fair_idle_wait", busy, 0);
    next_cycle();
    drive_req(0, 1'b1, 8'h60, LW'(1));
    drive_req(2, 1'b1, 8'h70, LW'(1));
    sample();
    chk("fair_req2_first", req_ready, 3'b100);
    next_cycle();
    drive_req(2, 1'b0, '0, '0);
    for (int c = 0; c < 10; c++) begin
      sample();
      if (req_ready != '0) break;
      next_cycle();
    end
    chk("fair_req0_next", req_ready, 3'b001);
    next_cycle();
    drive_req(0, 1'b0, '0, '0);
    repeat (6) next_cycle();

    // ---------------- reset in the middle of a burst ----------------
    do_reset();
    drive_req(0, 1'b1, 8'h30, LW'(8));
    sample();
    chk("mid_rst_ready", req_ready, 3'b001);
    next_cycle();
    drive_req(0, 1'b0, '0, '0);
    sample();
    chk("mid_rst_burst", bram_enb, 1);
    next_cycle();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    sample();
    chk("mid_rst_ready0", req_ready, 0);
    chk("mid_rst_enb0", bram_enb, 0);
    chk("mid_rst_addr0", bram_addrb, 0);
    chk("mid_rst_vld0", rd_valid, 0);
    chk("mid_rst_last0", rd_last, 0);
    chk("mid_rst_done0", done, 0);
    chk("mid_rst_busy0", busy, 0);
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      next_cycle();
      sample();
      if (rd_valid != '0 || done != '0 || bram_enb || rd_last) seen = 1'b1;
    end
    chk("mid_rst_no_stray", seen, 0);

    // ---------------- randomized run vs timeline model ----------------
    do_reset();
    for (int t = 0; t < HIST; t++) begin
      e_ready[t] = '0; e_en[t] = 1'b0; e_addr[t] = '0; e_vld[t] = '0;
      e_data[t] = '0; e_last[t] = 1'b0; e_done[t] = '0; e_busy[t] = 1'b0;
    end
    for (int r = 0; r < N; r++) begin pend[r] = 1'b0; rb[r] = '0; rl[r] = '0; end
    ptr = 0;
    free_at = 0;
    granted_last = -1;
    for (int c = 0; c < RAND_CYC; c++) begin
      // Requesters: drop on grant, occasionally withdraw, randomly raise new bursts.
      for (int r = 0; r < N; r++) begin
        if (pend[r] && granted_last == r) pend[r] = 1'b0;
        else if (pend[r] && $urandom_range(0, 99) < 3) pend[r] = 1'b0;
        if (!pend[r] && $urandom_range(0, 99) < 30) begin
          pend[r] = 1'b1;
          rb[r]   = AW'($urandom);
          rl[r]   = LW'($urandom_range(0, 6));
        end
        if (pend[r]) drive_req(r, 1'b1, rb[r], rl[r]);
        else drive_req(r, 1'b0, AW'($urandom), LW'($urandom));
      end
      granted_last = -1;
      // Model: a grant is only possible once the previous burst's timeline has ended.
      if (c >= free_at && (pend[0] || pend[1] || pend[2])) begin
        g = -1;
        for (int i = 0; i < N; i++) begin
          if (g < 0 && pend[(ptr + i) % N]) g = (ptr + i) % N;
        end
        e_ready[c]   = N'(1 << g);
        granted_last = g;
        cl = int'(rl[g]);
        if (cl == 0) begin
          e_done[c+1] = N'(1 << g);
          free_at = c + 2;
        end else begin
          for (int k = 0; k < cl; k++) begin
            e_en[c+1+k]       = 1'b1;
            e_addr[c+1+k]     = rb[g] + AW'(k);
            e_vld[c+1+k+LAT]  = N'(1 << g);
            e_data[c+1+k+LAT] = rb[g] + AW'(k);
          end
          e_last[c+cl+LAT] = 1'b1;
          e_done[c+cl+LAT] = N'(1 << g);
          free_at = c + cl + LAT + 1;
        end
        for (int t = c + 1; t < free_at; t++) e_busy[t] = 1'b1;
        ptr = (g + 1) % N;
      end
      sample();
      chk("rnd_ready", req_ready, e_ready[c]);
      chk("rnd_enb", bram_enb, e_en[c]);
      if (e_en[c]) chk("rnd_addrb", bram_addrb, e_addr[c]);
      chk("rnd_rd_valid", rd_valid, e_vld[c]);
      if (e_vld[c] != '0) chk("rnd_rd_data", rd_data, e_data[c]);
      chk("rnd_rd_last", rd_last, e_last[c]);
      chk("rnd_done", done, e_done[c]);
      chk("rnd_busy", busy, e_busy[c]);
      next_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
